// File: rtl/pll_freq_monitor.sv
// Gated frequency monitor: counts rising edges of two asynchronous clock-observation inputs over a window of monitor-clock cycles.
// Optional comparator (expected counts, tolerance, pass flag) is enabled by defining PLL_FREQ_MONITOR_CMP_EN.
module pll_freq_monitor #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             user_clk_mon,
    input  logic             core_clk_mon,
    input  logic [WIN_W-1:0] window,
    input  logic             start,
    input  logic             abort,
`ifdef PLL_FREQ_MONITOR_CMP_EN
    input  logic [CNT_W-1:0] exp_ucount,
    input  logic [CNT_W-1:0] exp_ccount,
    input  logic [7:0]       tol,
    output logic             pass,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ucount,
    output logic [CNT_W-1:0] ccount,
    output logic [1:0]       ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    // Channel 1 = user clock, channel 0 = core clock (matches ovf bit order).
    logic [1:0] mon_in;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] pulse_q, pulse_d;

    state_t                 state_q, state_d;
    logic [WIN_W-1:0]       rem_q, rem_d;
    logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]             ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

`ifdef PLL_FREQ_MONITOR_CMP_EN
    logic [CNT_W-1:0] exp_u_q, exp_u_d;
    logic [CNT_W-1:0] exp_c_q, exp_c_d;
    logic [7:0]       tol_q, tol_d;
    logic             pass_q, pass_d;

    function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                        input logic [CNT_W-1:0] b,
                                        input logic [7:0]       t);
        logic [CNT_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return ({8'd0, diff} <= {{CNT_W{1'b0}}, t});
    endfunction
`endif

    assign mon_in = {user_clk_mon, core_clk_mon};

    // Synchronizers and edge detectors run in every state so no edge is ever seen twice.
    always_comb begin
        sync1_d = mon_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef PLL_FREQ_MONITOR_CMP_EN
        exp_u_d = exp_u_q;
        exp_c_d = exp_c_q;
        tol_d   = tol_q;
        pass_d  = pass_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ovf_d   = 2'b00;
`ifdef PLL_FREQ_MONITOR_CMP_EN
            pass_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rem_d   = window;
                        cnt_d   = '0;
                        ovf_d   = 2'b00;
                        state_d = (window == '0) ? ST_DONE : ST_COUNT;
`ifdef PLL_FREQ_MONITOR_CMP_EN
                        exp_u_d = exp_ucount;
                        exp_c_d = exp_ccount;
                        tol_d   = tol;
                        // A zero window finishes immediately, so judge the zero counts now.
                        pass_d  = (window == '0) &&
                                  within_tol('0, exp_ucount, tol) &&
                                  within_tol('0, exp_ccount, tol);
`endif
                    end
                end
                ST_COUNT: begin
                    for (int i = 0; i < 2; i++) begin
                        if (pulse_q[i]) begin
                            if (cnt_q[i] == CNT_MAX) begin
                                ovf_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_ONE;
                            end
                        end
                    end
                    if (rem_q == WIN_ONE) begin
                        state_d = ST_DONE;
`ifdef PLL_FREQ_MONITOR_CMP_EN
                        pass_d  = within_tol(cnt_d[1], exp_u_q, tol_q) &&
                                  within_tol(cnt_d[0], exp_c_q, tol_q) &&
                                  (ovf_d == 2'b00);
`endif
                    end
                    rem_d = rem_q - WIN_ONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_COUNT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            pulse_q <= 2'b00;
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PLL_FREQ_MONITOR_CMP_EN
            exp_u_q <= '0;
            exp_c_q <= '0;
            tol_q   <= '0;
            pass_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PLL_FREQ_MONITOR_CMP_EN
            exp_u_q <= exp_u_d;
            exp_c_q <= exp_c_d;
            tol_q   <= tol_d;
            pass_q  <= pass_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ucount = cnt_q[1];
    assign ccount = cnt_q[0];
    assign ovf    = ovf_q;
`ifdef PLL_FREQ_MONITOR_CMP_EN
    assign pass   = pass_q;
`endif

endmodule
